// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : 8N1 UART receive path. Synchronizes the RX line, qualifies the
//            start bit at mid-bit, samples each data bit at its centre,
//            checks the stop bit and holds the byte in a one-entry
//            ready/valid output register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME         = SYMBOL_EDGE_TIME / 2;
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

  // Counter values at which the start bit (mid-bit) and the following bits
  // (one full bit period after the previous sample) are taken.
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] SAMPLE_LAST =
      CLOCK_COUNTER_WIDTH'(SAMPLE_TIME - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] SYMBOL_LAST =
      CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] COUNTER_ONE =
      CLOCK_COUNTER_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } state_e;

  state_e                         state_q;
  logic                           sync1_q;
  logic                           sync2_q;
  logic                           rx;
  logic [CLOCK_COUNTER_WIDTH-1:0] clock_counter_q;
  logic [2:0]                     bit_count_q;
  logic [7:0]                     shift_q;
  logic [7:0]                     shift_d;
  logic                           accept_d;
  logic [7:0]                     data_out_q;
  logic                           data_out_valid_q;
  logic                           framing_error_q;
  logic                           overrun_q;

  assign rx = sync2_q;

  // Two-flop synchronizer on the asynchronous line; idles high so reset
  // cannot fake a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
    end
  end

  // Next shift value (new bit enters at the MSB) and whether the output
  // register can take a new byte this cycle.
  always_comb begin
    shift_d  = {rx, shift_q[7:1]};
    accept_d = !data_out_valid_q || data_out_ready;
  end

  // Receive FSM with bit timer, bit counter, shift register and registered
  // ready/valid output plus error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      clock_counter_q  <= '0;
      bit_count_q      <= '0;
      shift_q          <= '0;
      data_out_q       <= 8'h00;
      data_out_valid_q <= 1'b0;
      framing_error_q  <= 1'b0;
      overrun_q        <= 1'b0;
    end else begin
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
      clock_counter_q <= clock_counter_q + COUNTER_ONE;

      // Consumer handshake; a same-cycle good frame overrides this below.
      if (data_out_valid_q && data_out_ready) begin
        data_out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          clock_counter_q <= '0;
          if (!rx) begin
            state_q <= START;
          end
        end

        START: begin
          if (clock_counter_q == SAMPLE_LAST) begin
            clock_counter_q <= '0;
            bit_count_q     <= '0;
            state_q         <= rx ? IDLE : DATA;
          end
        end

        DATA: begin
          if (clock_counter_q == SYMBOL_LAST) begin
            clock_counter_q <= '0;
            shift_q         <= shift_d;
            if (bit_count_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_count_q <= bit_count_q + 3'd1;
            end
          end
        end

        STOP: begin
          if (clock_counter_q == SYMBOL_LAST) begin
            clock_counter_q <= '0;
            if (rx) begin
              state_q <= IDLE;
              if (accept_d) begin
                data_out_q       <= shift_q;
                data_out_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              framing_error_q <= 1'b1;
              state_q         <= RECOVER;
            end
          end
        end

        RECOVER: begin
          // Wait out a held-low line so a break is not decoded as frames.
          clock_counter_q <= '0;
          if (rx) begin
            state_q <= IDLE;
          end
        end

        default: begin
          clock_counter_q <= '0;
          state_q         <= IDLE;
        end
      endcase
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign framing_error  = framing_error_q;
  assign overrun        = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Directed self-checking bench for uart_receiver at 10 cycles/bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  int n_vec;
  int n_err;

  // Event counters maintained by the monitor only.
  int         fe_cnt;
  int         ov_cnt;
  int         vh_cnt;
  logic       prev_valid;
  logic [7:0] got_q[$];

  uart_receiver #(
    .CLOCK_FREQ(1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe outputs mid-cycle, away from the rising edge.
  initial begin
    fe_cnt     = 0;
    ov_cnt     = 0;
    vh_cnt     = 0;
    prev_valid = 1'b0;
  end
  always @(negedge clk) begin
    if (!reset) begin
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (data_out_valid) vh_cnt++;
      if (data_out_valid && !prev_valid) got_q.push_back(data_out);
    end
    prev_valid = data_out_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then step 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame, LSB first, 10 cycles per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input int stop_cycles);
    serial_in = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(10);
    end
    serial_in = stop_val;
    tick(stop_cycles);
    serial_in = 1'b1;
  endtask

  task automatic pulse_ready();
    data_out_ready = 1'b1;
    tick(1);
    data_out_ready = 1'b0;
  endtask

  initial begin
    int fe0, ov0, vh0, q0;
    n_vec          = 0;
    n_err          = 0;
    reset          = 1'b1;
    serial_in      = 1'b1;
    data_out_ready = 1'b0;
    tick(3);
    check_eq("rst_data", {24'd0, data_out}, 32'h00);
    check_eq("rst_valid", {31'd0, data_out_valid}, 32'd0);
    check_eq("rst_ferr", {31'd0, framing_error}, 32'd0);
    check_eq("rst_ovr", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    tick(5);

    // 1: A5 held until consumed
    q0 = got_q.size();
    send_frame(8'hA5, 1'b1, 10);
    check_eq("t1_valid", {31'd0, data_out_valid}, 32'd1);
    check_eq("t1_data", {24'd0, data_out}, 32'hA5);
    tick(20);
    check_eq("t1_hold", {31'd0, data_out_valid}, 32'd1);
    check_eq("t1_nrx", got_q.size() - q0, 32'd1);
    pulse_ready();
    check_eq("t1_drop", {31'd0, data_out_valid}, 32'd0);
    tick(10);

    // 2: short glitch then 3C
    fe0 = fe_cnt;
    q0  = got_q.size();
    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    tick(30);
    check_eq("t2_noval", {31'd0, data_out_valid}, 32'd0);
    check_eq("t2_noferr", fe_cnt - fe0, 32'd0);
    send_frame(8'h3C, 1'b1, 10);
    check_eq("t2_data", {24'd0, data_out}, 32'h3C);
    check_eq("t2_nrx", got_q.size() - q0, 32'd1);
    pulse_ready();
    tick(10);

    // 3: framing error, held-low line, then 0F
    fe0 = fe_cnt;
    q0  = got_q.size();
    send_frame(8'h55, 1'b0, 50);
    tick(10);
    check_eq("t3_ferr", fe_cnt - fe0, 32'd1);
    check_eq("t3_noval", {31'd0, data_out_valid}, 32'd0);
    send_frame(8'h0F, 1'b1, 10);
    check_eq("t3_nrx", got_q.size() - q0, 32'd1);
    if (got_q.size() > q0) check_eq("t3_byte", {24'd0, got_q[q0]}, 32'h0F);
    check_eq("t3_data", {24'd0, data_out}, 32'h0F);
    check_eq("t3_ferr2", fe_cnt - fe0, 32'd1);
    pulse_ready();
    tick(10);

    // 4: overrun, then load on the consuming cycle
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 10);
    tick(10);
    send_frame(8'h22, 1'b1, 10);
    tick(5);
    check_eq("t4_ovr", ov_cnt - ov0, 32'd1);
    check_eq("t4_data", {24'd0, data_out}, 32'h11);
    check_eq("t4_valid", {31'd0, data_out_valid}, 32'd1);
    tick(10);
    ov0 = ov_cnt;
    fork
      send_frame(8'h33, 1'b1, 10);
      begin
        tick(97);
        data_out_ready = 1'b1;
        tick(1);
        data_out_ready = 1'b0;
      end
    join
    tick(3);
    check_eq("t4_data33", {24'd0, data_out}, 32'h33);
    check_eq("t4_valid33", {31'd0, data_out_valid}, 32'd1);
    check_eq("t4_noovr", ov_cnt - ov0, 32'd0);
    pulse_ready();
    tick(10);

    // 5: back-to-back FF, 00 with ready held
    q0  = got_q.size();
    vh0 = vh_cnt;
    data_out_ready = 1'b1;
    send_frame(8'hFF, 1'b1, 10);
    send_frame(8'h00, 1'b1, 10);
    tick(10);
    data_out_ready = 1'b0;
    check_eq("t5_nrx", got_q.size() - q0, 32'd2);
    if (got_q.size() >= q0 + 2) begin
      check_eq("t5_b0", {24'd0, got_q[q0]}, 32'hFF);
      check_eq("t5_b1", {24'd0, got_q[q0+1]}, 32'h00);
    end
    check_eq("t5_vhcyc", vh_cnt - vh0, 32'd2);

    // 6: park a byte, then reset during data bit 4
    send_frame(8'h5A, 1'b1, 10);
    check_eq("t6_pre", {24'd0, data_out}, 32'h5A);
    tick(10);
    fork
      send_frame(8'hF0, 1'b1, 10);
      begin
        tick(52);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("t6_rdata", {24'd0, data_out}, 32'h00);
        check_eq("t6_rvalid", {31'd0, data_out_valid}, 32'd0);
        check_eq("t6_rferr", {31'd0, framing_error}, 32'd0);
        check_eq("t6_rovr", {31'd0, overrun}, 32'd0);
      end
    join
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    q0  = got_q.size();
    tick(30);
    check_eq("t6_noval", {31'd0, data_out_valid}, 32'd0);
    send_frame(8'h81, 1'b1, 10);
    check_eq("t6_data", {24'd0, data_out}, 32'h81);
    check_eq("t6_valid", {31'd0, data_out_valid}, 32'd1);
    check_eq("t6_nrx", got_q.size() - q0, 32'd1);
    check_eq("t6_noerr", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
